// File: rtl/svpwm.sv
// Space-vector PWM modulator: alpha/beta Q15 reference to X/Y/Z, sector, dwell times,
// per-phase compare levels and six complementary gate drives against an external
// symmetric triangle carrier. Four register stages, one new sample accepted per cycle.
module svpwm #(
  parameter int K_SQRT3_2 = 28378,
  parameter int TS_FULL   = 32767
) (
  input  logic               tri_clk,
  input  logic               rst_n,
  input  logic signed [15:0] V_alpha,
  input  logic signed [15:0] V_beta,
  input  logic signed [15:0] carrier,
  output logic signed [15:0] X,
  output logic signed [15:0] Y,
  output logic signed [15:0] Z,
  output logic signed [15:0] Ta,
  output logic signed [15:0] Tb,
  output logic signed [15:0] T0,
  output logic signed [15:0] RefA,
  output logic signed [15:0] RefB,
  output logic signed [15:0] RefC,
  output logic [2:0]         sector,
  output logic [2:0]         switch,
  output logic [5:0]         gate
);

  localparam logic signed [31:0] KMul   = 32'(K_SQRT3_2);
  localparam logic signed [17:0] Full18 = 18'(TS_FULL);
  localparam logic [16:0]        Full17 = 17'(TS_FULL);

  // Map -32768 onto -32767 so the range is symmetric and negation never overflows.
  function automatic logic signed [15:0] clamp_in(input logic signed [15:0] v);
    return (v == 16'sh8000) ? 16'sh8001 : v;
  endfunction

  // Saturate a wide intermediate to +/-32767.
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    logic signed [15:0] r;
    if (v > 18'sd32767) begin
      r = 16'sd32767;
    end else if (v < -18'sd32767) begin
      r = -16'sd32767;
    end else begin
      r = 16'(v);
    end
    return r;
  endfunction

  // Value itself, with negative results forced to zero.
  function automatic logic signed [15:0] pos_clip(input logic signed [15:0] v);
    return v[15] ? 16'sd0 : v;
  endfunction

  // Saturating negation, with negative results forced to zero.
  function automatic logic signed [15:0] neg_clip(input logic signed [15:0] v);
    logic signed [15:0] r;
    if (!v[15]) begin
      r = 16'sd0;
    end else if (v == 16'sh8000) begin
      r = 16'sd32767;
    end else begin
      r = -v;
    end
    return r;
  endfunction

  // ---------------- stage 1: X/Y/Z ----------------
  logic signed [15:0] va_c, vb_c, vb_half;
  logic signed [31:0] ka_prod;
  logic signed [17:0] ka18, y_pre, z_pre;
  logic signed [15:0] x_d, y_d, z_d;

  // Input clamp, Ka = Va*sqrt(3)/2, and saturated Y/Z.
  always_comb begin
    va_c    = clamp_in(V_alpha);
    vb_c    = clamp_in(V_beta);
    vb_half = vb_c >>> 1;
    ka_prod = 32'(va_c) * KMul;
    ka18    = 18'(ka_prod >>> 15);
    y_pre   = 18'(vb_half) + ka18;
    z_pre   = 18'(vb_half) - ka18;
    x_d     = vb_c;
    y_d     = sat16(y_pre);
    z_d     = sat16(z_pre);
  end

  // ---------------- stage 2: sector and dwell ----------------
  logic [2:0]         sec_d;
  logic signed [15:0] ta_p, tb_p;
  logic [16:0]        sum17;
  logic signed [15:0] ta_d, tb_d, t0_d;

  // Sector decode from X/Y/Z signs; codes 100/011 cannot occur geometrically, fall to 1.
  always_comb begin
    sec_d = 3'd1;
    case ({~X[15], ~Y[15], ~Z[15]})
      3'b110:  sec_d = 3'd1;
      3'b111:  sec_d = 3'd2;
      3'b101:  sec_d = 3'd3;
      3'b001:  sec_d = 3'd4;
      3'b000:  sec_d = 3'd5;
      3'b010:  sec_d = 3'd6;
      default: sec_d = 3'd1;
    endcase
  end

  // Active-vector dwell selection plus overmodulation limiting.
  always_comb begin
    ta_p = 16'sd0;
    tb_p = 16'sd0;
    case (sec_d)
      3'd1: begin ta_p = neg_clip(Z); tb_p = pos_clip(X); end
      3'd2: begin ta_p = pos_clip(Y); tb_p = pos_clip(Z); end
      3'd3: begin ta_p = pos_clip(X); tb_p = neg_clip(Y); end
      3'd4: begin ta_p = pos_clip(Z); tb_p = neg_clip(X); end
      3'd5: begin ta_p = neg_clip(Y); tb_p = neg_clip(Z); end
      3'd6: begin ta_p = neg_clip(X); tb_p = pos_clip(Y); end
      default: begin ta_p = 16'sd0; tb_p = 16'sd0; end
    endcase
    sum17 = {1'b0, ta_p} + {1'b0, tb_p};
    ta_d  = ta_p;
    if (sum17 > Full17) begin
      // Keep Ta, trim Tb so the period is fully used by active vectors.
      tb_d = 16'(Full17 - {1'b0, ta_p});
      t0_d = 16'sd0;
    end else begin
      tb_d = tb_p;
      t0_d = 16'(Full17 - sum17);
    end
  end

  // ---------------- stage 3: compare levels ----------------
  logic signed [15:0] tmid;
  logic signed [17:0] t0_18, rl18, rm18, rs18;
  logic signed [15:0] rl, rm, rs;
  logic signed [15:0] ref_a_d, ref_b_d, ref_c_d;

  // Low/mid/high levels, then routed to phases by sector.
  always_comb begin
    tmid    = sector[0] ? Tb : Ta;
    t0_18   = 18'(T0);
    rl18    = t0_18 - Full18;
    rm18    = t0_18 + (18'(tmid) <<< 1) - Full18;
    rs18    = Full18 - t0_18;
    rl      = sat16(rl18);
    rm      = sat16(rm18);
    rs      = sat16(rs18);
    ref_a_d = 16'sd0;
    ref_b_d = 16'sd0;
    ref_c_d = 16'sd0;
    case (sector)
      3'd1: begin ref_a_d = rl; ref_b_d = rm; ref_c_d = rs; end
      3'd2: begin ref_b_d = rl; ref_a_d = rm; ref_c_d = rs; end
      3'd3: begin ref_b_d = rl; ref_c_d = rm; ref_a_d = rs; end
      3'd4: begin ref_c_d = rl; ref_b_d = rm; ref_a_d = rs; end
      3'd5: begin ref_c_d = rl; ref_a_d = rm; ref_b_d = rs; end
      3'd6: begin ref_a_d = rl; ref_c_d = rm; ref_b_d = rs; end
      default: begin ref_a_d = 16'sd0; ref_b_d = 16'sd0; ref_c_d = 16'sd0; end
    endcase
  end

  // ---------------- stage 4: carrier compare ----------------
  logic signed [15:0] car_q1, car_q2, car_q3;
  logic               vld_q1, vld_q2, vld_q3;
  logic [2:0]         sw_d;

  // Strict compare: carrier equal to the level leaves the upper switch off.
  always_comb begin
    sw_d = {car_q3 > RefA, car_q3 > RefB, car_q3 > RefC};
  end

  // Pipeline registers; the valid chain keeps gates off until the first real sample lands.
  always_ff @(posedge tri_clk or negedge rst_n) begin
    if (!rst_n) begin
      X      <= '0;
      Y      <= '0;
      Z      <= '0;
      sector <= '0;
      Ta     <= '0;
      Tb     <= '0;
      T0     <= '0;
      RefA   <= '0;
      RefB   <= '0;
      RefC   <= '0;
      switch <= '0;
      gate   <= '0;
      car_q1 <= '0;
      car_q2 <= '0;
      car_q3 <= '0;
      vld_q1 <= 1'b0;
      vld_q2 <= 1'b0;
      vld_q3 <= 1'b0;
    end else begin
      X      <= x_d;
      Y      <= y_d;
      Z      <= z_d;
      car_q1 <= carrier;
      vld_q1 <= 1'b1;
      sector <= sec_d;
      Ta     <= ta_d;
      Tb     <= tb_d;
      T0     <= t0_d;
      car_q2 <= car_q1;
      vld_q2 <= vld_q1;
      RefA   <= ref_a_d;
      RefB   <= ref_b_d;
      RefC   <= ref_c_d;
      car_q3 <= car_q2;
      vld_q3 <= vld_q2;
      if (vld_q3) begin
        switch <= sw_d;
        gate   <= {sw_d[2], ~sw_d[2], sw_d[1], ~sw_d[1], sw_d[0], ~sw_d[0]};
      end else begin
        switch <= '0;
        gate   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_svpwm.sv
// Directed bench for svpwm: reset/latency, hand-computed vectors, and a full rotation.
module tb_svpwm;

  logic               tri_clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] V_alpha, V_beta, carrier;
  logic signed [15:0] X, Y, Z, Ta, Tb, T0, RefA, RefB, RefC;
  logic [2:0]         sector, switch;
  logic [5:0]         gate;

  int total = 0;
  int bad   = 0;

  svpwm dut (
    .tri_clk (tri_clk),
    .rst_n   (rst_n),
    .V_alpha (V_alpha),
    .V_beta  (V_beta),
    .carrier (carrier),
    .X       (X),
    .Y       (Y),
    .Z       (Z),
    .Ta      (Ta),
    .Tb      (Tb),
    .T0      (T0),
    .RefA    (RefA),
    .RefB    (RefB),
    .RefC    (RefC),
    .sector  (sector),
    .switch  (switch),
    .gate    (gate)
  );

  always #5 tri_clk = ~tri_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tri_clk);
    @(negedge tri_clk);
  endtask

  // Drive a vector at a falling edge and let it fill all four stages.
  task automatic apply(input int va, input int vb, input int car);
    V_alpha = 16'(va);
    V_beta  = 16'(vb);
    carrier = 16'(car);
    repeat (4) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    real ang;
    int  va, vb, car, p, prev, sum;
    logic [7:0] seen;

    // Reset held with nonzero inputs.
    rst_n   = 1'b0;
    V_alpha = 16'sd16384;
    V_beta  = 16'sd0;
    carrier = 16'sd0;
    repeat (3) @(posedge tri_clk);
    @(negedge tri_clk);
    chk("rst_X", X, 0);
    chk("rst_Y", Y, 0);
    chk("rst_Z", Z, 0);
    chk("rst_sector", sector, 0);
    chk("rst_Ta", Ta, 0);
    chk("rst_Tb", Tb, 0);
    chk("rst_T0", T0, 0);
    chk("rst_RefA", RefA, 0);
    chk("rst_RefB", RefB, 0);
    chk("rst_RefC", RefC, 0);
    chk("rst_switch", switch, 0);
    chk("rst_gate", gate, 0);

    // Release and track the first sample through the pipeline (Va=16384, Vb=0, carrier=0).
    rst_n = 1'b1;
    step();
    chk("lat1_X", X, 0);
    chk("lat1_Y", Y, 14189);
    chk("lat1_Z", Z, -14189);
    chk("lat1_gate", gate, 0);
    step();
    chk("lat2_sector", sector, 1);
    chk("lat2_gate", gate, 0);
    step();
    chk("lat3_RefA", RefA, -14189);
    chk("lat3_gate", gate, 0);
    step();
    chk("lat4_gate", gate, 6'b101001);
    chk("v3_Ta", Ta, 14189);
    chk("v3_Tb", Tb, 0);
    chk("v3_T0", T0, 18578);
    chk("v3_RefB", RefB, -14189);
    chk("v3_RefC", RefC, 14189);
    chk("v3_switch", switch, 3'b110);

    // Zero reference.
    apply(0, 0, 100);
    chk("v2_X", X, 0);
    chk("v2_Y", Y, 0);
    chk("v2_Z", Z, 0);
    chk("v2_sector", sector, 2);
    chk("v2_Ta", Ta, 0);
    chk("v2_Tb", Tb, 0);
    chk("v2_T0", T0, 32767);
    chk("v2_RefA", RefA, 0);
    chk("v2_RefB", RefB, 0);
    chk("v2_RefC", RefC, 0);
    chk("v2_switch", switch, 3'b111);
    chk("v2_gate", gate, 6'b101010);

    // Pure beta.
    apply(0, 16384, -100);
    chk("v4_X", X, 16384);
    chk("v4_Y", Y, 8192);
    chk("v4_Z", Z, 8192);
    chk("v4_sector", sector, 2);
    chk("v4_Ta", Ta, 8192);
    chk("v4_Tb", Tb, 8192);
    chk("v4_T0", T0, 16383);
    chk("v4_RefA", RefA, 0);
    chk("v4_RefB", RefB, -16384);
    chk("v4_RefC", RefC, 16384);
    chk("v4_switch", switch, 3'b010);
    chk("v4_gate", gate, 6'b011001);

    // Overmodulation; carrier equals RefB so phase B must stay low.
    apply(32767, 32767, 8779);
    chk("v5_X", X, 32767);
    chk("v5_Y", Y, 32767);
    chk("v5_Z", Z, -11994);
    chk("v5_sector", sector, 1);
    chk("v5_Ta", Ta, 11994);
    chk("v5_Tb", Tb, 20773);
    chk("v5_T0", T0, 0);
    chk("v5_RefA", RefA, -32767);
    chk("v5_RefB", RefB, 8779);
    chk("v5_RefC", RefC, 32767);
    chk("v5_switch", switch, 3'b100);
    chk("v5_gate", gate, 6'b100101);

    // Input clamp: -32768 behaves like -32767.
    apply(0, -32768, 0);
    chk("clamp_X", X, -32767);

    // Full rotation at 1 degree per cycle with a triangle carrier.
    apply(20000, 0, -32767);
    prev = 1;
    seen = 8'h00;
    for (int i = 0; i < 360; i++) begin
      ang = real'(i) * 3.14159265358979 / 180.0;
      va  = int'(20000.0 * $cos(ang));
      vb  = int'(20000.0 * $sin(ang));
      p   = i % 62;
      car = (p <= 31) ? (-32767 + p * 2114) : (32767 - (p - 31) * 2114);
      V_alpha = 16'(va);
      V_beta  = 16'(vb);
      carrier = 16'(car);
      step();
      chk("rot_sector_order", int'(sector == 3'(prev) || sector == 3'(prev + 1)), 1);
      sum = int'(Ta) + int'(Tb) + int'(T0);
      chk("rot_dwell_sum", sum, 32767);
      chk("rot_gate_compl",
          int'((gate[5] ^ gate[4]) & (gate[3] ^ gate[2]) & (gate[1] ^ gate[0])), 1);
      prev = int'(sector);
      seen[sector] = 1'b1;
    end
    chk("rot_all_sectors", int'(seen), 8'b0111_1110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
